// File: rtl/x_uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-timer derivation helpers,
// common to the RX and TX sides of the x_ UART link.
package x_uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK
  } uart_rx_sm_t;

  // Clock cycles per bit period; the timer runs 0..timer_top-1.
  function automatic int unsigned timer_top(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

  function automatic int unsigned timer_half(input int unsigned top);
    return top / 2;
  endfunction

  function automatic int unsigned timer_width(input int unsigned top);
    return (top <= 2) ? 1 : $clog2(top);
  endfunction

endpackage

// File: rtl/x_uart_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input; the reset value is a
// parameter so an idle-high line does not look like a start bit coming out of reset.
module x_uart_sync #(
  parameter logic p_rst_val = 1'b1
) (
  input  logic i_clk,
  input  logic i_nrst,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] ff_q;

  // NOTE: non-blocking assignments so both flops sample the pre-edge values; blocking
  // here would collapse the chain into a single flop.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) ff_q <= {2{p_rst_val}};
    else         ff_q <= {ff_q[0], i_d};
  end

  assign o_q = ff_q[1];

endmodule

// File: rtl/x_uart_rx.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) with a valid/ready
// holding register and single-cycle framing, overrun and parity error pulses.
module x_uart_rx
  import x_uart_pkg::*;
#(
  parameter int unsigned p_clk_hz = 12000000,
  parameter int unsigned p_baud   = 115200
) (
  input  logic       i_clk,
  input  logic       i_nrst,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_parity_err
);

  localparam int unsigned p_timer_top  = timer_top(p_clk_hz, p_baud);
  localparam int unsigned p_timer_half = timer_half(p_timer_top);
  localparam int unsigned lp_tw        = timer_width(p_timer_top);
  localparam logic [lp_tw-1:0] lp_bit_end = lp_tw'(p_timer_top - 1);
  localparam logic [lp_tw-1:0] lp_mid     = lp_tw'(p_timer_half - 1);

  logic rx_s;

  uart_rx_sm_t      state_q, state_d;
  logic [lp_tw-1:0] timer_q, timer_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             load;
`ifdef UART_RX_PARITY_EN
  logic             par_q, par_d;
  logic             parity_err_q, parity_err_d;
`endif

  x_uart_sync #(.p_rst_val(1'b1)) u_sync (
    .i_clk  (i_clk),
    .i_nrst (i_nrst),
    .i_d    (i_uart_rx),
    .o_q    (rx_s)
  );

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    load        = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif
    unique case (state_q)
      RX_IDLE:  if (!rx_s) state_d = RX_START;
      RX_START: if (timer_q == lp_mid) state_d = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA: begin
        if (timer_q == lp_bit_end) begin
          shift_d[cnt_q] = rx_s;
          cnt_d          = cnt_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (cnt_q == 3'd7) state_d = RX_PARITY;
`else
          if (cnt_q == 3'd7) state_d = RX_STOP;
`endif
        end
      end
      RX_PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (timer_q == lp_bit_end) begin
          par_d   = rx_s;
          state_d = RX_STOP;
        end
`else
        state_d = RX_IDLE;
`endif
      end
      RX_STOP: begin
        if (timer_q == lp_bit_end) begin
          if (!rx_s) begin
            frame_err_d = 1'b1;
            state_d     = RX_BREAK;
          end else begin
            state_d = RX_IDLE;
`ifdef UART_RX_PARITY_EN
            // Even parity: data bits plus parity bit must XOR to zero.
            if (^{shift_q, par_q}) parity_err_d = 1'b1;
            else                   load         = 1'b1;
`else
            load = 1'b1;
`endif
          end
        end
      end
      RX_BREAK: if (rx_s) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase

    if (state_d != state_q)                       timer_d = '0;
    else if (state_q inside {RX_IDLE, RX_BREAK})  timer_d = timer_q;
    else if (timer_q == lp_bit_end)               timer_d = '0;
    else                                          timer_d = timer_q + 1'b1;
  end

  // Holding register: a new byte is dropped only if the old one is not leaving this cycle.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (load) begin
      if (valid_q && !i_ready) begin
        overrun_d = 1'b1;
      end else begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q      <= RX_IDLE;
      timer_q      <= '0;
      cnt_q        <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = parity_err_q;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_x_uart_rx.sv
// Scoreboard bench for x_uart_rx: frames are modelled at transaction level when sent,
// and a negedge monitor pops and compares whenever the receiver presents a byte or error.
module tb_x_uart_rx;

  localparam int BIT = 12000000 / 115200;
`ifdef UART_RX_PARITY_EN
  localparam int  FRAME_BITS = 11;
  localparam bit  PAR_EN     = 1'b1;
`else
  localparam int  FRAME_BITS = 10;
  localparam bit  PAR_EN     = 1'b0;
`endif
  // A byte should appear about half a bit into the stop bit, measured from the start edge.
  localparam int LAT_NOM = (FRAME_BITS - 1) * BIT + BIT / 2;

  logic       i_clk = 1'b0;
  logic       i_nrst = 1'b0;
  logic       i_uart_rx = 1'b1;
  logic       i_ready = 1'b1;
  logic [7:0] o_data;
  logic       o_valid, o_frame_err, o_overrun, o_parity_err;

  x_uart_rx dut (
    .i_clk        (i_clk),
    .i_nrst       (i_nrst),
    .i_uart_rx    (i_uart_rx),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_frame_err  (o_frame_err),
    .o_overrun    (o_overrun),
    .o_parity_err (o_parity_err)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef enum int {EV_FRAME, EV_OVERRUN, EV_PARITY} ev_t;
  typedef struct {
    logic [7:0] d;
    int         t0;
  } exp_byte_t;

  exp_byte_t byte_q[$];
  ev_t       ev_q[$];
  int        n_vec = 0;
  int        n_err = 0;
  bit        hold_full = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  task automatic expect_ev(input ev_t got, input string name);
    ev_t e;
    if (ev_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got an unexpected pulse, expected none (cycle %0d)", name, cyc);
    end else begin
      e = ev_q.pop_front();
      check(name, got, e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    i_uart_rx = b;
    tick(BIT);
  endtask

  // Sends one frame; the outcome is predicted from the frame contents and the consumer state.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic bad_par);
    exp_byte_t e;
    if (!stop_bit)              ev_q.push_back(EV_FRAME);
    else if (PAR_EN && bad_par) ev_q.push_back(EV_PARITY);
    else if (hold_full)         ev_q.push_back(EV_OVERRUN);
    else begin
      e.d  = d;
      e.t0 = cyc;
      byte_q.push_back(e);
      if (!i_ready) hold_full = 1'b1;
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ bad_par);
`endif
    drive_bit(stop_bit);
  endtask

  initial begin : monitor
    logic      prev_valid;
    exp_byte_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge i_clk);
      if (!i_nrst) begin
        prev_valid = 1'b0;
      end else begin
        if (o_valid && !prev_valid && byte_q.size() != 0)
          check_range("valid_latency", cyc - byte_q[0].t0, LAT_NOM - 4, LAT_NOM + 8);
        if (o_valid && i_ready) begin
          if (byte_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_byte: got 0x%02h, expected no byte (cycle %0d)", o_data, cyc);
          end else begin
            e = byte_q.pop_front();
            check("rx_data", o_data, e.d);
          end
        end
        if (o_frame_err)  expect_ev(EV_FRAME, "frame_err");
        if (o_overrun)    expect_ev(EV_OVERRUN, "overrun");
        if (o_parity_err) expect_ev(EV_PARITY, "parity_err");
        prev_valid = o_valid;
      end
    end
  end

  initial begin : stimulus
    logic [7:0] d;
    logic       bad_stop, bad_par;

    tick(5);
    check("rst_valid", o_valid, 1'b0);
    check("rst_data", o_data, 8'h00);
    check("rst_errs", {o_frame_err, o_overrun, o_parity_err}, 3'b000);
    i_nrst = 1'b1;
    tick(20);

    // Clean byte with an always-ready consumer.
    send_frame(8'hA5, 1'b1, 1'b0);
    tick(BIT);

    // Short low glitch must be rejected silently.
    i_uart_rx = 1'b0;
    tick(20);
    i_uart_rx = 1'b1;
    tick(2 * BIT);

    // Bad stop bit followed by a held-low line, then recovery.
    send_frame(8'h3C, 1'b0, 1'b0);
    tick(500);
    i_uart_rx = 1'b1;
    tick(2 * BIT);
    send_frame(8'h5A, 1'b1, 1'b0);
    tick(BIT);

    // Stalled consumer: second byte overruns, first is held.
    i_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    tick(BIT);
    check("hold_valid", o_valid, 1'b1);
    check("hold_data", o_data, 8'h11);
    i_ready   = 1'b1;
    hold_full = 1'b0;
    tick(1);
    check("valid_drop", o_valid, 1'b0);
    tick(BIT);

    // Reset in the middle of bit 3 of 0xFF.
    i_uart_rx = 1'b0;
    tick(BIT);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    tick(BIT / 2);
    i_nrst    = 1'b0;
    hold_full = 1'b0;
    tick(3);
    check("midrst_valid", o_valid, 1'b0);
    check("midrst_data", o_data, 8'h00);
    check("midrst_errs", {o_frame_err, o_overrun, o_parity_err}, 3'b000);
    i_uart_rx = 1'b1;
    tick(2);
    i_nrst = 1'b1;
    tick(2 * BIT);
    send_frame(8'h0F, 1'b1, 1'b0);
    tick(BIT);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    tick(BIT);
    send_frame(8'h07, 1'b1, 1'b0);
    tick(BIT);
`endif

    // Randomised traffic: glitches, bad stop bits, bad parity and idle gaps.
    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        i_uart_rx = 1'b0;
        tick($urandom_range(1, 40));
        i_uart_rx = 1'b1;
        tick(BIT);
      end
      d        = 8'($urandom);
      bad_stop = ($urandom_range(0, 4) == 0);
      bad_par  = PAR_EN && ($urandom_range(0, 4) == 0);
      send_frame(d, !bad_stop, bad_par);
      if (bad_stop) begin
        tick($urandom_range(0, 300));
        i_uart_rx = 1'b1;
        tick(BIT);
      end
      tick($urandom_range(0, 200));
    end

    tick(2 * BIT);
    check("pending_bytes", byte_q.size(), 0);
    check("pending_events", ev_q.size(), 0);
    check("final_valid", o_valid, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
